// File: rtl/img2col_out_packer.sv
`timescale 1ns/1ps
// img2col_out_packer: packs PACK consecutive IN_W-bit im2col words into one wide beat and keeps packet boundaries.
// Defining PACKER_BEAT_CNT_EN adds the m_beat_cnt port, a free-running count of handed-off beats.
module img2col_out_packer #(
   parameter int IN_W = 64,
   parameter int PACK = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [IN_W-1:0]      s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [IN_W*PACK-1:0] m_data,
   output logic [PACK-1:0]      m_keep,
   output logic                 m_last,
   output logic                 m_valid,
   input  logic                 m_ready
`ifdef PACKER_BEAT_CNT_EN
   ,
   output logic [31:0]          m_beat_cnt
`endif
);

   localparam int              CW        = $clog2(PACK);
   localparam logic [CW-1:0]   LAST_LANE = CW'(PACK - 1);

   logic [IN_W*PACK-1:0] r_acc_data;
   logic [CW-1:0]        r_acc_cnt;
   logic [IN_W*PACK-1:0] r_m_data;
   logic [PACK-1:0]      r_m_keep;
   logic                 r_m_last;
   logic                 r_m_valid;

   logic                 w_closing_possible;
   logic                 w_xfer;
   logic                 w_close;
   logic [IN_W*PACK-1:0] w_beat_data;
   logic [PACK-1:0]      w_beat_keep;

   // A closing word only waits when the held beat is not leaving this cycle.
   assign w_closing_possible = (r_acc_cnt == LAST_LANE) || s_last;
   assign s_ready            = !w_closing_possible || !r_m_valid || m_ready;
   assign w_xfer             = s_valid && s_ready;
   assign w_close            = w_xfer && w_closing_possible;

   for (genvar k = 0; k < PACK; k++) begin : g_lane
      localparam logic [CW-1:0] LANE = CW'(k);

      assign w_beat_data[k*IN_W +: IN_W] = (LANE < r_acc_cnt)  ? r_acc_data[k*IN_W +: IN_W] :
                                           (LANE == r_acc_cnt) ? s_data : '0;
      assign w_beat_keep[k] = (LANE <= r_acc_cnt);

      // NOTE: accumulator lanes carry no reset; a lane is only read once r_acc_cnt has passed it.
      always_ff @(posedge clk) begin
         if (w_xfer && (r_acc_cnt == LANE)) begin
            r_acc_data[k*IN_W +: IN_W] <= s_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc_cnt <= '0;
         r_m_data  <= '0;
         r_m_keep  <= '0;
         r_m_last  <= 1'b0;
         r_m_valid <= 1'b0;
      end else if (clear) begin
         r_acc_cnt <= '0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (w_close) begin
         // A load on the same edge as a drain simply replaces the old beat.
         r_acc_cnt <= '0;
         r_m_data  <= w_beat_data;
         r_m_keep  <= w_beat_keep;
         r_m_last  <= s_last;
         r_m_valid <= 1'b1;
      end else begin
         if (w_xfer) begin
            r_acc_cnt <= r_acc_cnt + CW'(1);
         end
         if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign m_data  = r_m_data;
   assign m_keep  = r_m_keep;
   assign m_last  = r_m_last;
   assign m_valid = r_m_valid;

`ifdef PACKER_BEAT_CNT_EN
   logic [31:0] r_beat_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_beat_cnt <= '0;
      end else if (clear) begin
         r_beat_cnt <= '0;
      end else if (r_m_valid && m_ready) begin
         r_beat_cnt <= r_beat_cnt + 32'd1;
      end
   end

   assign m_beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_img2col_out_packer.sv
`timescale 1ns/1ps
// tb_img2col_out_packer: directed, self-checking bench for img2col_out_packer at IN_W=64, PACK=4.
module tb_img2col_out_packer;

   logic         clk;
   logic         reset;
   logic         clear;
   logic [63:0]  s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic [255:0] m_data;
   logic [3:0]   m_keep;
   logic         m_last;
   logic         m_valid;
   logic         m_ready;
`ifdef PACKER_BEAT_CNT_EN
   logic [31:0]  m_beat_cnt;
`endif

   typedef struct {
      logic [255:0] data;
      logic [3:0]   keep;
      logic         last;
   } beat_t;

   beat_t beats[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    stall_cnt = 0;

   img2col_out_packer #(.IN_W(64), .PACK(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_keep  (m_keep),
      .m_last  (m_last),
      .m_valid (m_valid),
      .m_ready (m_ready)
`ifdef PACKER_BEAT_CNT_EN
      ,
      .m_beat_cnt (m_beat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change only at posedge+1, so the negedge view equals what the next posedge will use.
   always @(negedge clk) begin
      if (reset && !clear && m_valid && m_ready) begin
         beats.push_back('{data: m_data, keep: m_keep, last: m_last});
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [255:0] lanes(input logic [63:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic push(input logic [63:0] d, input logic l);
      int waits = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge clk);
      while (!s_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!s_ready) check("push_timeout", 256'(s_ready), 256'(1));
      stall_cnt += waits;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic check_beat(input string tag, input int i, input logic [255:0] d,
                             input logic [3:0] k, input logic l);
      if (i < beats.size()) begin
         check($sformatf("%s_data", tag), beats[i].data, d);
         check($sformatf("%s_keep", tag), 256'(beats[i].keep), 256'(k));
         check($sformatf("%s_last", tag), 256'(beats[i].last), 256'(l));
      end else begin
         check($sformatf("%s_present", tag), 256'(beats.size()), 256'(i + 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset   = 1'b0;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b1;

      // Reset state
      #12;
      check("rst_m_valid", 256'(m_valid), 256'(0));
      check("rst_m_last",  256'(m_last),  256'(0));
      check("rst_m_keep",  256'(m_keep),  256'(0));
      check("rst_m_data",  m_data,        256'(0));
`ifdef PACKER_BEAT_CNT_EN
      check("rst_beat_cnt", 256'(m_beat_cnt), 256'(0));
`endif
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_s_ready", 256'(s_ready), 256'(1));

      // Full rate: 16 words, four full beats, no stalls
      beats.delete();
      stall_cnt = 0;
      for (int i = 1; i <= 16; i++) push(64'(i), i == 16);
      idle(3);
      check("full_stalls", 256'(stall_cnt), 256'(0));
      check("full_nbeats", 256'(beats.size()), 256'(4));
      for (int b = 0; b < 4; b++) begin
         check_beat($sformatf("full_b%0d", b), b,
                    lanes(64'(4*b+1), 64'(4*b+2), 64'(4*b+3), 64'(4*b+4)), 4'hF, b == 3);
      end

      // Short final group: 6 words -> full beat then 2-lane beat
      beats.delete();
      for (int i = 1; i <= 6; i++) push(64'h20 + 64'(i), i == 6);
      idle(3);
      check("short_nbeats", 256'(beats.size()), 256'(2));
      check_beat("short_b0", 0, lanes(64'h21, 64'h22, 64'h23, 64'h24), 4'hF, 1'b0);
      check_beat("short_b1", 1, lanes(64'h25, 64'h26, 64'h0, 64'h0), 4'h3, 1'b1);

      // s_last on lane 0, and one-cycle load latency
      beats.delete();
      push(64'hAB, 1'b1);
      m_ready = 1'b0;
      @(negedge clk);
      check("lane0_valid", 256'(m_valid), 256'(1));
      check("lane0_keep",  256'(m_keep),  256'(1));
      check("lane0_data",  m_data,        lanes(64'hAB, 64'h0, 64'h0, 64'h0));
      check("lane0_last",  256'(m_last),  256'(1));
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      idle(2);
      check("lane0_drained", 256'(m_valid), 256'(0));

      // Backpressure: beat 0 held, words 5-7 accepted, word 8 stalls
      beats.delete();
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(64'(i), 1'b0);
      stall_cnt = 0;
      for (int i = 5; i <= 7; i++) push(64'(i), 1'b0);
      check("bp_w567_stalls", 256'(stall_cnt), 256'(0));
      s_valid = 1'b1;
      s_data  = 64'd8;
      s_last  = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("bp_w8_stalled", 256'(s_ready), 256'(0));
         check("bp_hold_valid", 256'(m_valid), 256'(1));
         check("bp_hold_data",  m_data, lanes(64'd1, 64'd2, 64'd3, 64'd4));
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(negedge clk);
      check("bp_w8_ready", 256'(s_ready), 256'(1));
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check("bp_swap_valid", 256'(m_valid), 256'(1));
      check("bp_swap_data",  m_data, lanes(64'd5, 64'd6, 64'd7, 64'd8));
      check("bp_swap_keep",  256'(m_keep), 256'(4'hF));
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      idle(2);
      check("bp_nbeats", 256'(beats.size()), 256'(2));
      check_beat("bp_b0", 0, lanes(64'd1, 64'd2, 64'd3, 64'd4), 4'hF, 1'b0);

      // clear drops a held beat
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(64'h70 + 64'(i), i == 4);
      @(negedge clk);
      check("clr_pre_valid", 256'(m_valid), 256'(1));
      @(posedge clk);
      #1;
      pulse_clear();
      @(negedge clk);
      check("clr_valid", 256'(m_valid), 256'(0));
      check("clr_last",  256'(m_last),  256'(0));
      @(posedge clk);
      #1;

      // clear mid-group: partial words are dropped
      m_ready = 1'b1;
      beats.delete();
      push(64'h31, 1'b0);
      push(64'h32, 1'b0);
      pulse_clear();
      for (int i = 1; i <= 4; i++) push(64'h40 + 64'(i), 1'b0);
      idle(3);
      check("clr_nbeats", 256'(beats.size()), 256'(1));
      check_beat("clr_b0", 0, lanes(64'h41, 64'h42, 64'h43, 64'h44), 4'hF, 1'b0);

      // Async reset between edges with a held beat and a partial group
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(64'h50 + 64'(i), i == 4);
      push(64'h55, 1'b0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_valid", 256'(m_valid), 256'(0));
      check("arst_last",  256'(m_last),  256'(0));
      check("arst_keep",  256'(m_keep),  256'(0));
      check("arst_data",  m_data,        256'(0));
      reset = 1'b1;
      @(posedge clk);
      #1;
      beats.delete();
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(64'h60 + 64'(i), i == 4);
      idle(3);
      check("arst_nbeats", 256'(beats.size()), 256'(1));
      check_beat("arst_b0", 0, lanes(64'h61, 64'h62, 64'h63, 64'h64), 4'hF, 1'b1);

`ifdef PACKER_BEAT_CNT_EN
      // Beat counter: 100 handed-off beats, then clear
      pulse_clear();
      check("cnt_after_clr0", 256'(m_beat_cnt), 256'(0));
      for (int i = 0; i < 400; i++) push(64'(i), 1'b0);
      idle(3);
      check("cnt_100", 256'(m_beat_cnt), 256'(100));
      pulse_clear();
      check("cnt_after_clr1", 256'(m_beat_cnt), 256'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
